exc_flush_ctrl: RTL and testbench
=================================

EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

Interface
REQ-001 SHALL have parameter EX_VECTOR, default 32'hBFC00380: fetch target on exception.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..15: number of cycles the flush pulse lasts.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port wb_ex, input, 1: a valid WB instruction raised an exception this cycle.
REQ-006 SHALL have port wb_eret, input, 1: a valid WB eret committed this cycle.
REQ-007 SHALL have port wb_hlt, input, 1: halt request from CP0.
REQ-008 SHALL have port epc, input, 32: CP0 EPC value.
REQ-009 SHALL have port ie, input, 1: STATUS.IE.
REQ-010 SHALL have port exl, input, 1: STATUS.EXL.
REQ-011 SHALL have port int_mask, input, 8: STATUS.IM.
REQ-012 SHALL have port int_sig, input, 8: CAUSE.IP.
REQ-013 SHALL have port redirect_ready, input, 1: IF stage accepts the redirect.
REQ-014 SHALL have port flush, output, 1: clear the valid bits of all stages IF..WB.
REQ-015 SHALL have port fetch_stall, output, 1: IF holds its PC.
REQ-016 SHALL have port redirect_valid, output, 1: redirect_pc is valid.
REQ-017 SHALL have port redirect_pc, output, 32: next fetch address.
REQ-018 SHALL have port int_pending, output, 1: tag the ID-stage instruction with an interrupt.
REQ-019 SHALL have port halted, output, 1: the core is stopped.
REQ-020 SHALL have port ex_count, output, 16: saturating count of accepted exceptions.
REQ-021 SHALL have port eret_count, output, 16: saturating count of accepted erets.

Function
REQ-022 SHALL implement a registered FSM with states IDLE, FLUSH, REDIRECT, HALT.
REQ-023 SHALL, in IDLE, evaluate events with priority wb_hlt > wb_ex > wb_eret and move on the next edge as follows:
- wb_hlt -> HALT.
- wb_ex -> FLUSH, latching target = EX_VECTOR.
- wb_eret -> FLUSH, latching target = the epc sampled in that same cycle.
REQ-024 SHALL, when wb_ex and wb_eret are asserted together, accept only wb_ex; eret_count does not increment.
REQ-025 SHALL load a 4-bit counter with FLUSH_CYCLES-1 on entering FLUSH, decrement it each cycle, and go to REDIRECT on the cycle after the counter reads 0.
REQ-026 SHALL keep flush=1 for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the event.
REQ-027 SHALL, in REDIRECT, drive redirect_valid=1 with redirect_pc = the latched target and hold both stable until redirect_ready=1.
REQ-028 SHALL go from REDIRECT to IDLE on the edge where redirect_valid & redirect_ready; redirect_valid=0 from the next cycle.
REQ-029 SHALL set latency event -> redirect_valid at FLUSH_CYCLES+1 cycles when redirect_ready is held at 1.
REQ-030 SHALL drive fetch_stall=1 in every state except IDLE.
REQ-031 SHALL drive redirect_pc = 0 whenever redirect_valid = 0.
REQ-032 SHALL ignore wb_ex, wb_eret and wb_hlt while in FLUSH or REDIRECT: no state change, no count change.
REQ-033 SHALL, in HALT, drive flush=1, fetch_stall=1, halted=1 and redirect_valid=0, and leave HALT only on rst.
REQ-034 SHALL register int_pending: next value = state==IDLE & ie & !exl & |(int_sig & int_mask) & !wb_ex & !wb_eret & !wb_hlt.
REQ-035 SHALL increment ex_count / eret_count by 1 on the edge an event is accepted in IDLE, and stick at 16'hFFFF.

Reset
REQ-036 SHALL, on rst, force state=IDLE and load every output to these values:
- flush=0, fetch_stall=0, redirect_valid=0, redirect_pc=0.
- int_pending=0, halted=0, ex_count=0, eret_count=0.
REQ-037 SHALL give rst priority over all events, including rst asserted mid-FLUSH, in REDIRECT or in HALT; the latched target and counter are discarded.

Verification
REQ-038 SHALL check a single exception: wb_ex pulse in cycle 10, redirect_ready=1 -> flush=1 in cycles 11-12, redirect_valid=1 with pc 32'hBFC00380 in cycle 13, IDLE in cycle 14, ex_count=1.
REQ-039 SHALL check eret with backpressure: epc=32'h00400010, wb_eret pulse, redirect_ready=0 for 5 cycles -> redirect_valid and pc held for those 5 cycles, released 1 cycle after ready=1, eret_count=1.
REQ-040 SHALL check simultaneous events: wb_ex=wb_eret=1 -> target EX_VECTOR, ex_count=1, eret_count=0; a wb_ex during FLUSH -> ignored.
REQ-041 SHALL check halt: wb_hlt together with wb_ex -> HALT, halted=1, flush=1 held for 100 cycles; rst -> all outputs 0, state IDLE.
REQ-042 SHALL check interrupts: ie=1, exl=0, int_mask=8'h04, int_sig=8'h04 -> int_pending=1 the next cycle; exl=1 or int_mask=0 -> int_pending=0 the next cycle.
REQ-043 SHALL check saturation: preload via 65536 wb_ex events -> ex_count stays at 16'hFFFF.

Source files
------------

// File: rtl/exc_flush_ctrl.sv
// rtl/exc_flush_ctrl.sv - exception/eret/halt pipeline flush and fetch redirect controller
module exc_flush_ctrl #(
    parameter logic [31:0] EX_VECTOR    = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_ex,
    input  logic        wb_eret,
    input  logic        wb_hlt,
    input  logic [31:0] epc,
    input  logic        ie,
    input  logic        exl,
    input  logic [7:0]  int_mask,
    input  logic [7:0]  int_sig,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        fetch_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        int_pending,
    output logic        halted,
    output logic [15:0] ex_count,
    output logic [15:0] eret_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HALT
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] ex_cnt_q, eret_cnt_q;
    logic        int_pending_q;
    logic        accept_ex, accept_eret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            target_q      <= 32'h0;
            cnt_q         <= 4'h0;
            ex_cnt_q      <= 16'h0;
            eret_cnt_q    <= 16'h0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            cnt_q         <= cnt_d;
            if (accept_ex && ex_cnt_q != 16'hFFFF) begin
                ex_cnt_q <= ex_cnt_q + 16'd1;
            end
            if (accept_eret && eret_cnt_q != 16'hFFFF) begin
                eret_cnt_q <= eret_cnt_q + 16'd1;
            end
            // An interrupt is only tagged when no WB event is about to flush the pipe.
            int_pending_q <= (state_q == S_IDLE) && ie && !exl && (|(int_sig & int_mask))
                             && !wb_ex && !wb_eret && !wb_hlt;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        accept_ex   = 1'b0;
        accept_eret = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_hlt) begin
                    state_d = S_HALT;
                end else if (wb_ex) begin
                    state_d   = S_FLUSH;
                    target_d  = EX_VECTOR;
                    cnt_d     = CNT_LOAD;
                    accept_ex = 1'b1;
                end else if (wb_eret) begin
                    state_d     = S_FLUSH;
                    target_d    = epc;
                    cnt_d       = CNT_LOAD;
                    accept_eret = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'h0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign flush          = (state_q == S_FLUSH) || (state_q == S_HALT);
    assign fetch_stall    = (state_q != S_IDLE);
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = redirect_valid ? target_q : 32'h0;
    assign halted         = (state_q == S_HALT);
    assign int_pending    = int_pending_q;
    assign ex_count       = ex_cnt_q;
    assign eret_count     = eret_cnt_q;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb/tb_exc_flush_ctrl.sv - scoreboard bench for exc_flush_ctrl
module tb_exc_flush_ctrl;

    localparam logic [31:0] EXV = 32'hBFC00380;
    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_ex = 1'b0, wb_eret = 1'b0, wb_hlt = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        ie = 1'b0, exl = 1'b0;
    logic [7:0]  int_mask = 8'h0, int_sig = 8'h0;
    logic        redirect_ready = 1'b0;
    logic        flush, fetch_stall, redirect_valid, int_pending, halted;
    logic [31:0] redirect_pc;
    logic [15:0] ex_count, eret_count;

    always #5 clk = ~clk;

    exc_flush_ctrl #(.EX_VECTOR(EXV), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .wb_ex(wb_ex), .wb_eret(wb_eret), .wb_hlt(wb_hlt),
        .epc(epc), .ie(ie), .exl(exl), .int_mask(int_mask), .int_sig(int_sig),
        .redirect_ready(redirect_ready), .flush(flush), .fetch_stall(fetch_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .int_pending(int_pending), .halted(halted),
        .ex_count(ex_count), .eret_count(eret_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: expected redirect targets, in order of acceptance.
    logic [31:0] exp_q[$];
    bit          busy_m, halted_m, hs_seen, mon_en;
    bit          acc_busy, acc_halt, acc_ex, acc_er;
    logic [15:0] exp_ex, exp_eret;
    bit          exp_ip_now, exp_ip_next;
    int          bcyc;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model decides acceptance from its own idea of busy/halted.
    task automatic cyc(bit ex, bit er, bit hl, logic [31:0] pc, bit rdy,
                       bit ie_i, bit exl_i, logic [7:0] m, logic [7:0] s);
        @(posedge clk);
        #1;
        if (hs_seen) begin
            busy_m  = 0;
            hs_seen = 0;
        end
        if (acc_busy) busy_m = 1;
        if (acc_halt) halted_m = 1;
        if (acc_ex && exp_ex != 16'hFFFF) exp_ex = exp_ex + 16'd1;
        if (acc_er && exp_eret != 16'hFFFF) exp_eret = exp_eret + 16'd1;
        acc_busy = 0; acc_halt = 0; acc_ex = 0; acc_er = 0;
        exp_ip_now = exp_ip_next;
        wb_ex = ex; wb_eret = er; wb_hlt = hl; epc = pc; redirect_ready = rdy;
        ie = ie_i; exl = exl_i; int_mask = m; int_sig = s;
        if (!busy_m && !halted_m) begin
            if (hl) begin
                acc_halt = 1;
            end else if (ex) begin
                exp_q.push_back(EXV);
                acc_busy = 1; acc_ex = 1;
            end else if (er) begin
                exp_q.push_back(pc);
                acc_busy = 1; acc_er = 1;
            end
        end
        exp_ip_next = !busy_m && !halted_m && ie_i && !exl_i && ((m & s) != 8'h0)
                      && !ex && !er && !hl;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 1, 0, 0, 8'h0, 8'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (busy_m || acc_busy || hs_seen); i++) idle(1);
        chk1("drain_idle", busy_m || acc_busy, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(posedge clk);
        #1;
        rst = 1;
        wb_ex = 0; wb_eret = 0; wb_hlt = 0; epc = 32'h0; redirect_ready = 0;
        ie = 0; exl = 0; int_mask = 8'h0; int_sig = 8'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        exp_q.delete();
        busy_m = 0; halted_m = 0; hs_seen = 0;
        acc_busy = 0; acc_halt = 0; acc_ex = 0; acc_er = 0;
        exp_ex = 16'h0; exp_eret = 16'h0; exp_ip_now = 0; exp_ip_next = 0; bcyc = 0;
        rst = 0;
        #2;
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_fetch_stall", fetch_stall, 1'b0);
        chk1("rst_redirect_valid", redirect_valid, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);
        chk1("rst_int_pending", int_pending, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk16("rst_ex_count", ex_count, 16'h0);
        chk16("rst_eret_count", eret_count, 16'h0);
        mon_en = 1;
    endtask

    // Monitor: compares DUT outputs with the model every cycle and retires targets on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk1("fetch_stall", fetch_stall, busy_m || halted_m);
            chk1("flush", flush, halted_m || (busy_m && bcyc < F));
            chk1("halted", halted, halted_m);
            chk1("redirect_valid", redirect_valid, busy_m && !halted_m && bcyc >= F);
            if (redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk1("redirect_unexpected", 1'b1, 1'b0);
                end else begin
                    chk32("redirect_pc", redirect_pc, exp_q[0]);
                    if (redirect_ready) begin
                        void'(exp_q.pop_front());
                        hs_seen = 1;
                    end
                end
            end else begin
                chk32("redirect_pc_idle", redirect_pc, 32'h0);
            end
            chk16("ex_count", ex_count, exp_ex);
            chk16("eret_count", eret_count, exp_eret);
            chk1("int_pending", int_pending, exp_ip_now);
            bcyc = busy_m ? bcyc + 1 : 0;
        end
    end

    initial begin
        do_reset();

        // Single exception in cycle 10 after reset.
        idle(10);
        cyc(1, 0, 0, 32'h0, 1, 0, 0, 8'h0, 8'h0);
        idle(4);
        chk16("single_ex_count", ex_count, 16'd1);
        chk1("single_back_idle", fetch_stall, 1'b0);
        drain();

        // Eret with 5 cycles of redirect backpressure.
        cyc(0, 1, 0, 32'h00400010, 0, 0, 0, 8'h0, 8'h0);
        for (int i = 0; i < F + 5; i++) cyc(0, 0, 0, 32'h0, 0, 0, 0, 8'h0, 8'h0);
        chk1("bp_valid_held", redirect_valid, 1'b1);
        chk32("bp_pc_held", redirect_pc, 32'h00400010);
        cyc(0, 0, 0, 32'h0, 1, 0, 0, 8'h0, 8'h0);
        idle(1);
        chk1("bp_released", redirect_valid, 1'b0);
        chk16("bp_eret_count", eret_count, 16'd1);
        drain();

        // Simultaneous ex+eret, then an ignored ex during FLUSH.
        cyc(1, 1, 0, 32'h12345678, 1, 0, 0, 8'h0, 8'h0);
        cyc(1, 0, 0, 32'h0, 1, 0, 0, 8'h0, 8'h0);
        drain();
        chk16("simul_ex_count", ex_count, 16'd2);
        chk16("simul_eret_count", eret_count, 16'd1);

        // Interrupt pending and its masking.
        cyc(0, 0, 0, 32'h0, 1, 1, 0, 8'h04, 8'h04);
        cyc(0, 0, 0, 32'h0, 1, 1, 1, 8'h04, 8'h04);
        #2 chk1("int_set", int_pending, 1'b1);
        cyc(0, 0, 0, 32'h0, 1, 1, 0, 8'h00, 8'h04);
        #2 chk1("int_exl_clr", int_pending, 1'b0);
        idle(1);
        #2 chk1("int_mask_clr", int_pending, 1'b0);

        // Halt wins over a simultaneous exception and holds until reset.
        cyc(1, 0, 1, 32'h0, 1, 0, 0, 8'h0, 8'h0);
        for (int i = 0; i < 100; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                1, 0, 0, 8'h0, 8'h0);
        chk1("halt_held", halted, 1'b1);
        chk1("halt_flush", flush, 1'b1);
        do_reset();

        // Saturation: counters preloaded near the top, then pushed past it.
        idle(1);
        force dut.ex_cnt_q = 16'hFFFD;
        force dut.eret_cnt_q = 16'hFFFE;
        exp_ex = 16'hFFFD;
        exp_eret = 16'hFFFE;
        #1;
        release dut.ex_cnt_q;
        release dut.eret_cnt_q;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 32'h0, 1, 0, 0, 8'h0, 8'h0);
            drain();
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, $urandom, 1, 0, 0, 8'h0, 8'h0);
            drain();
        end
        chk16("sat_ex_count", ex_count, 16'hFFFF);
        chk16("sat_eret_count", eret_count, 16'hFFFF);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1'b0, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                8'($urandom), 8'($urandom));
        drain();

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
